// File: rtl/wb_fetch_master.sv
// wb_fetch_master
// Pipelined Wishbone read master. Streams a programmed range of 32-bit words
// from a block-RAM slave into an internal FIFO that a downstream consumer
// drains over a valid/ready handshake. One request per clock when the slave
// does not stall. Requests are issued only while the FIFO has room for every
// word already in flight, so the FIFO cannot overflow.
//
// Optional feature (macro WB_FETCH_LOOP_EN): continuous scan. With i_loop
// high at start, the range is re-issued back to back until i_loop is seen
// low at a pass end. Without the macro, i_loop is ignored.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_start           start pulse (sampled in IDLE only)
//   i_base, i_count   first word address and word count (0..2^ADDR_W)
//   i_loop            continuous-scan request (optional feature only)
//   o_busy, o_done    transfer in progress / one-cycle completion pulse
//   o_wb_*            Wishbone master request side (cyc, stb, we, addr)
//   i_wb_*            Wishbone slave response side (stall, ack, data)
//   o_valid, o_data   FIFO non-empty / FIFO head word
//   i_ready           consumer pop
module wb_fetch_master #(
    parameter int ADDR_W  = 7,
    parameter int FIFO_AW = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_base,
    input  logic [ADDR_W:0]   i_count,
    input  logic              i_loop,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_wb_cyc,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [ADDR_W-1:0] o_wb_addr,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic [31:0]       i_wb_data,
    output logic              o_valid,
    output logic [31:0]       o_data,
    input  logic              i_ready
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW+1:0] DEPTH_L = (FIFO_AW+2)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W:0]     remain_r;
    logic [FIFO_AW:0]    outst_r, outst_nxt;
    logic [FIFO_AW:0]    fcnt_r;
    logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
    logic [31:0]         mem [DEPTH];
    logic                done_r, done_nxt;

    logic [FIFO_AW+1:0]  inflight;
    logic                credit, stb_w, accept, ack_v, push, pop;
    logic                start_ok, last_acc;
    logic                loop_cont, pass_done;
    logic [ADDR_W-1:0]   reload_addr;
    logic [ADDR_W:0]     reload_cnt;

    // Words in the FIFO plus words requested but not yet returned must never
    // exceed the FIFO depth; this is the issue credit.
    assign inflight = {1'b0, fcnt_r} + {1'b0, outst_r};
    assign credit   = inflight < DEPTH_L;
    assign stb_w    = (state == S_ISSUE) && credit;
    assign accept   = stb_w && !i_wb_stall;
    // Acks outside a bus cycle (e.g. after a reset) are stale and dropped.
    assign ack_v    = i_wb_ack && (state != S_IDLE) && (outst_r != '0);
    assign push     = ack_v;
    assign pop      = (fcnt_r != '0) && i_ready;
    assign start_ok = (state == S_IDLE) && i_start && (i_count != '0);
    assign last_acc = accept && (remain_r == (ADDR_W+1)'(1));

`ifdef WB_FETCH_LOOP_EN
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W:0]   count_r;
    logic              loop_r;
    logic [ADDR_W:0]   ack_rem_r;

    assign loop_cont   = loop_r && i_loop;
    assign reload_addr = base_r;
    assign reload_cnt  = count_r;
    // ack_rem_r counts acks left in the current pass so done can mark each
    // pass end even while the next pass is already being issued.
    assign pass_done   = ack_v && (ack_rem_r == (ADDR_W+1)'(1));

    always_ff @(posedge clk) begin
        if (start_ok) begin
            base_r  <= i_base;
            count_r <= i_count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            loop_r    <= 1'b0;
            ack_rem_r <= '0;
        end else begin
            if (start_ok) begin
                loop_r    <= i_loop;
                ack_rem_r <= i_count;
            end else begin
                if (last_acc && !i_loop)
                    loop_r <= 1'b0;
                if (ack_v)
                    ack_rem_r <= (ack_rem_r == (ADDR_W+1)'(1)) ? count_r
                                                                : ack_rem_r - 1'b1;
            end
        end
    end
`else
    logic unused_loop;
    assign unused_loop = i_loop;
    assign loop_cont   = 1'b0;
    assign reload_addr = '0;
    assign reload_cnt  = '0;
    assign pass_done   = 1'b0;
`endif

    always_comb begin
        outst_nxt = outst_r;
        if (accept && !ack_v)
            outst_nxt = outst_r + 1'b1;
        else if (!accept && ack_v)
            outst_nxt = outst_r - 1'b1;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_count == '0)
                        done_nxt = 1'b1;
                    else
                        state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (last_acc && !loop_cont)
                    state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                // Leave on the cycle the final ack lands so done follows it by one clock.
                if (outst_nxt == '0) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
        if (pass_done)
            done_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            addr_r   <= '0;
            remain_r <= '0;
            outst_r  <= '0;
            fcnt_r   <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            done_r   <= 1'b0;
        end else begin
            state   <= state_nxt;
            outst_r <= outst_nxt;
            done_r  <= done_nxt;
            if (start_ok) begin
                addr_r   <= i_base;
                remain_r <= i_count;
            end else if (accept) begin
                if (last_acc && loop_cont) begin
                    addr_r   <= reload_addr;
                    remain_r <= reload_cnt;
                end else begin
                    addr_r   <= addr_r + 1'b1;
                    remain_r <= remain_r - 1'b1;
                end
            end
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fcnt_r <= fcnt_r + 1'b1;
                2'b01:   fcnt_r <= fcnt_r - 1'b1;
                default: fcnt_r <= fcnt_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= i_wb_data;
    end

    assign o_busy    = (state != S_IDLE);
    assign o_wb_cyc  = (state != S_IDLE);
    assign o_wb_stb  = stb_w;
    assign o_wb_we   = 1'b0;
    assign o_wb_addr = addr_r;
    assign o_done    = done_r;
    assign o_valid   = (fcnt_r != '0);
    // Head is gated so the data output reads zero whenever nothing is held.
    assign o_data    = (fcnt_r != '0) ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_wb_fetch_master.sv
module tb_wb_fetch_master;
    localparam int AW    = 7;
    localparam int FAW   = 3;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_start;
    logic [AW-1:0] i_base;
    logic [AW:0]   i_count;
    logic          i_loop;
    logic          o_busy, o_done, o_wb_cyc, o_wb_stb, o_wb_we;
    logic [AW-1:0] o_wb_addr;
    logic          i_wb_stall, i_wb_ack;
    logic [31:0]   i_wb_data;
    logic          o_valid;
    logic [31:0]   o_data;
    logic          i_ready;

    always #5 clk = ~clk;

    wb_fetch_master #(.ADDR_W(AW), .FIFO_AW(FAW)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_base(i_base),
        .i_count(i_count), .i_loop(i_loop), .o_busy(o_busy), .o_done(o_done),
        .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_addr(o_wb_addr), .i_wb_stall(i_wb_stall), .i_wb_ack(i_wb_ack),
        .i_wb_data(i_wb_data), .o_valid(o_valid), .o_data(o_data),
        .i_ready(i_ready)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]   ram [128];
    logic [31:0]   exp_data [$];
    logic [AW-1:0] exp_addr [$];
    logic [AW-1:0] pend [$];

    int stall_pct   = 0;
    int ack_pct     = 100;
    int ready_pct   = 100;
    int stall_force = 0;
    bit ack_inject  = 1'b0;
    int acc_total   = 0;
    int pop_total   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model: zero or random wait states, random stalls, in-order acks.
    initial begin
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_data  = '0;
        i_ready    = 1'b0;
        forever begin
            @(negedge clk);
            i_ready = ($urandom_range(99) < 32'(ready_pct));
            if (rst) begin
                pend.delete();
                i_wb_ack   = 1'b0;
                i_wb_stall = 1'b0;
            end else begin
                if (ack_inject) begin
                    i_wb_ack   = 1'b1;
                    i_wb_data  = 32'hDEADBEEF;
                    ack_inject = 1'b0;
                end else if (pend.size() > 0 && $urandom_range(99) < 32'(ack_pct)) begin
                    i_wb_ack  = 1'b1;
                    i_wb_data = ram[pend.pop_front()];
                end else begin
                    i_wb_ack  = 1'b0;
                    i_wb_data = $urandom;
                end
                if (o_wb_stb && stall_force > 0) begin
                    i_wb_stall = 1'b1;
                    stall_force--;
                end else begin
                    i_wb_stall = ($urandom_range(99) < 32'(stall_pct));
                end
                if (o_wb_stb && !i_wb_stall)
                    pend.push_back(o_wb_addr);
            end
        end
    end

    // Monitor: compares every delivered word and every accepted request.
    initial begin
        forever begin
            int infl;
            @(negedge clk);
            #1;
            infl = acc_total - pop_total;
            if (o_valid && i_ready) begin
                if (exp_data.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL data: unexpected word %h, none expected", o_data);
                end else begin
                    chk("data", o_data, exp_data.pop_front());
                end
                pop_total++;
            end
            if (o_wb_stb && !i_wb_stall) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL addr: unexpected request %h, none expected", o_wb_addr);
                end else begin
                    chk("addr", 32'(o_wb_addr), 32'(exp_addr.pop_front()));
                end
                chk("credit", 32'(infl < DEPTH), 32'd1);
                acc_total++;
            end
        end
    end

    task automatic start_xfer(input int base, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            exp_data.push_back(ram[(base + i) % 128]);
            exp_addr.push_back(7'((base + i) % 128));
        end
        @(negedge clk);
        i_start = 1'b1;
        i_base  = 7'(base);
        i_count = 8'(cnt);
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            #1;
            if (o_done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk(name, 32'(seen), 32'd1);
        chk({name, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic wait_drain(input string name);
        ready_pct = 100;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            #2;
            if (!o_valid) break;
        end
        chk({name, "_words_left"}, 32'(exp_data.size()), 32'd0);
        chk({name, "_reqs_left"}, 32'(exp_addr.size()), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_base  = '0;
        i_count = '0;
        i_loop  = 1'b0;
        foreach (ram[i]) ram[i] = $urandom;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy",  32'(o_busy),    32'd0);
        chk("rst_done",  32'(o_done),    32'd0);
        chk("rst_cyc",   32'(o_wb_cyc),  32'd0);
        chk("rst_stb",   32'(o_wb_stb),  32'd0);
        chk("rst_addr",  32'(o_wb_addr), 32'd0);
        chk("rst_valid", 32'(o_valid),   32'd0);
        chk("rst_data",  o_data,         32'd0);
        chk("we_tied",   32'(o_wb_we),   32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Zero-wait slave, consumer always ready: exact cycle timeline.
        start_xfer(16, 4);
        for (int k = 1; k <= 7; k++) begin
            #1;
            chk($sformatf("t1_stb_c%0d", k),   32'(o_wb_stb), 32'(k <= 4));
            if (k <= 4)
                chk($sformatf("t1_addr_c%0d", k), 32'(o_wb_addr), 32'(16 + k - 1));
            chk($sformatf("t1_cyc_c%0d", k),   32'(o_wb_cyc), 32'(k <= 5));
            chk($sformatf("t1_valid_c%0d", k), 32'(o_valid),  32'(k >= 3 && k <= 6));
            chk($sformatf("t1_done_c%0d", k),  32'(o_done),   32'(k == 6));
            @(negedge clk);
        end
        wait_drain("t1");

        // Consumer stalled: credit limits requests to the FIFO depth.
        begin
            int acc_base;
            acc_base  = acc_total;
            ready_pct = 0;
            start_xfer(48, 20);
            repeat (20) @(negedge clk);
            #2;
            chk("t2_accepted", 32'(acc_total - acc_base), 32'(DEPTH));
            chk("t2_stb_low",  32'(o_wb_stb), 32'd0);
            chk("t2_cyc_high", 32'(o_wb_cyc), 32'd1);
            chk("t2_valid",    32'(o_valid),  32'd1);
            ready_pct = 100;
            @(negedge clk);
            wait_done("t2_done");
            wait_drain("t2");
        end

        // Address wrap, plus a start pulse while busy that must be ignored.
        start_xfer(126, 4);
        i_start = 1'b1;
        i_base  = 7'h55;
        i_count = 8'd3;
        @(negedge clk);
        i_start = 1'b0;
        wait_done("t3_done");
        wait_drain("t3");

        // Zero count: no request, done the following cycle, never busy.
        start_xfer(32, 0);
        #1;
        chk("t4_done", 32'(o_done), 32'd1);
        chk("t4_busy", 32'(o_busy), 32'd0);
        chk("t4_stb",  32'(o_wb_stb), 32'd0);
        @(negedge clk);
        #1;
        chk("t4_done_off", 32'(o_done), 32'd0);
        chk("t4_cyc",      32'(o_wb_cyc), 32'd0);

        // Stall on the first request for three cycles.
        stall_force = 3;
        start_xfer(16, 5);
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("t5_stb_c%0d", k),  32'(o_wb_stb),  32'd1);
            chk($sformatf("t5_addr_c%0d", k), 32'(o_wb_addr), 32'd16);
            @(negedge clk);
        end
        wait_done("t5_done");
        wait_drain("t5");

        // Reset in the middle of a transfer.
        start_xfer(32, 16);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        exp_data.delete();
        exp_addr.delete();
        acc_total = 0;
        pop_total = 0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_cyc",   32'(o_wb_cyc), 32'd0);
        chk("t6_stb",   32'(o_wb_stb), 32'd0);
        chk("t6_valid", 32'(o_valid),  32'd0);
        chk("t6_busy",  32'(o_busy),   32'd0);
        ack_inject = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("t6_stale_ack", 32'(o_valid), 32'd0);
        start_xfer(0, 2);
        wait_done("t6_done");
        wait_drain("t6");

        // Randomized transfers under random stalls, wait states and backpressure.
        for (int r = 0; r < 12; r++) begin
            stall_pct = int'($urandom_range(50));
            ack_pct   = int'($urandom_range(100, 30));
            ready_pct = int'($urandom_range(100, 20));
            start_xfer(int'($urandom_range(127)), int'($urandom_range(40, 1)));
            wait_done($sformatf("rnd%0d_done", r));
            wait_drain($sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/wb_fetch_master.md
Name: wb_fetch_master

Overview:
Pipelined Wishbone read master that sits directly upstream of the block-RAM slave. Streams a programmed range of 32-bit words out of the RAM into an internal FIFO, which a consumer drains over a valid/ready interface (e.g. the VGA pixel path). Issues one request per clock when the slave does not stall. Limits outstanding requests so the FIFO can never overflow.

Parameters:
ADDR_W, 7, word address width; matches the RAM address port.
FIFO_AW, 3, FIFO depth is 2^FIFO_AW words.

Ports:
clk  in  1  system clock, all logic on posedge.
rst  in  1  synchronous active-high reset.
i_start  in  1  start pulse; sampled only in IDLE.
i_base  in  ADDR_W  first word address, captured on start.
i_count  in  ADDR_W+1  number of words, 0..2^ADDR_W, captured on start.
i_loop  in  1  continuous-scan request; used only with the optional feature.
o_busy  out  1  high from accepted start until return to IDLE.
o_done  out  1  one-cycle completion pulse.
o_wb_cyc  out  1  bus cycle; high in ISSUE and DRAIN.
o_wb_stb  out  1  request strobe.
o_wb_we  out  1  tied 0.
o_wb_addr  out  ADDR_W  request address.
i_wb_stall  in  1  slave stall.
i_wb_ack  in  1  slave acknowledge; data valid in the same cycle.
i_wb_data  in  32  read data.
o_valid  out  1  FIFO non-empty.
o_data  out  32  FIFO head word.
i_ready  in  1  consumer pop.

Behaviour:
- Reset values: o_busy=0, o_done=0, o_wb_cyc=0, o_wb_stb=0, o_wb_addr=0, o_valid=0, o_data=0. FIFO, outstanding counter and remaining counter cleared.
- States: IDLE, ISSUE, DRAIN.
- IDLE: on i_start, capture base/count.
  - count=0: stay IDLE, pulse o_done next cycle, no strobe.
  - count>0: go to ISSUE with o_busy=1.
- ISSUE: o_wb_stb=1 only while credit exists, i.e. fifo_count + outstanding < 2^FIFO_AW; otherwise stb is held low with cyc still high.
  - A request is accepted on a cycle with stb && !stall. Acceptance increments addr (modulo 2^ADDR_W, so 0x7F wraps to 0x00), decrements remaining, and increments outstanding.
  - Under stall, addr and stb are held stable. No duplicate request is counted.
  - Last request accepted: go to DRAIN with stb=0.
- DRAIN: cyc held high until outstanding=0, then IDLE, o_busy=0, and o_done pulses for one cycle.
- Ack handling: each i_wb_ack while cyc=1 pushes i_wb_data into the FIFO and decrements outstanding. Acks while cyc=0 are ignored.
  - Simultaneous accept and ack in the same cycle leaves outstanding unchanged.
- FIFO: pop on o_valid && i_ready.
  - Push and pop in the same cycle are both honoured, including when full.
  - No bypass: a word pushed into an empty FIFO is visible on o_valid the next cycle.
- Latency with a zero-wait slave: start sampled in cycle 0, stb in cycle 1, ack in cycle 2, o_valid in cycle 3. Sustained throughput is 1 word/clk while i_ready=1.
- i_start while busy is ignored.
- rst mid-transfer: everything returns to reset values next cycle and FIFO contents are discarded. Late acks are ignored because cyc=0.

Optional Feature:
Macro WB_FETCH_LOOP_EN.
- Defined, with i_loop=1 at start: after the last request of a pass is accepted, addr reloads to base and remaining reloads to count, and the block stays in ISSUE with no DRAIN gap. o_done pulses on the ack of each pass's final word. i_loop is re-sampled at each pass end; once low, the block finishes the current pass, then runs DRAIN and returns to IDLE.
- Undefined: i_loop is ignored and the block is one-shot only.

Test Plan:
- base=0x10, count=4, no stall, i_ready=1 -> stb in 4 consecutive cycles with addr 0x10..0x13; words out in order on o_valid in cycles 3..6; o_done one cycle after the last ack.
- count=20, FIFO depth 8, i_ready=0 -> at most 8 requests accepted, then stb drops with cyc high. Raise i_ready -> all 20 words delivered in order, no loss, no overflow.
- base=0x7E, count=4 -> addresses 0x7E, 0x7F, 0x00, 0x01.
- count=0 -> no stb; o_done pulse the cycle after start; o_busy stays 0.
- i_wb_stall high for 3 cycles on the first request -> addr stays 0x10 and stb stays high; exactly count words returned.
- rst asserted in the middle of a count=16 transfer -> next cycle cyc, stb, valid, busy = 0. A subsequent start with base=0, count=2 completes normally.
